// File: rtl/audio_stream_engine.sv
// Audio datapath between a codec read/write handshake and a synchronous sample RAM.
// Supports live passthrough, looped RAM playback and record-with-monitor, with output attenuation.
module audio_stream_engine #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LOOP_LEN = 48000,
  parameter int unsigned ATTEN_W  = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  input  logic [ATTEN_W-1:0] atten,
  input  logic               read_ready,
  input  logic               write_ready,
  input  logic [DATA_W-1:0]  readdata_left,
  input  logic [DATA_W-1:0]  readdata_right,
  output logic               read,
  output logic               write,
  output logic [DATA_W-1:0]  writedata_left,
  output logic [DATA_W-1:0]  writedata_right,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_wren,
  input  logic [DATA_W-1:0]  mem_q,
  output logic               loop_done
);

  localparam logic [1:0]        MODE_PASS = 2'b00;
  localparam logic [1:0]        MODE_PLAY = 2'b01;
  localparam logic [1:0]        MODE_REC  = 2'b10;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOOP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_XFER  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                held_q, held_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wl_q, wl_d;
  logic [DATA_W-1:0]   wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wren_q, wren_d;
  logic                loop_done_q, loop_done_d;

  logic [1:0]          mode_eff_c;
  logic                mode_chg_c;
  logic [ADDR_W-1:0]   next_addr_c;
  logic [DATA_W-1:0]   play_sample_c;

  function automatic logic [DATA_W-1:0] atten_f(input logic [DATA_W-1:0] x,
                                                input logic [ATTEN_W-1:0] sh);
    logic signed [DATA_W-1:0] s;
    s = $signed(x);
    return DATA_W'(s >>> sh);
  endfunction

  // Mode 11 is an alias of passthrough, so it never counts as a mode change against 00.
  always_comb begin
    mode_eff_c    = (mode == 2'b11) ? MODE_PASS : mode;
    mode_chg_c    = (mode_eff_c != mode_q);
    next_addr_c   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    play_sample_c = held_q ? sample_q : mem_q;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_eff_c;
    sample_d    = sample_q;
    held_d      = held_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    wl_d        = wl_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wren_d      = 1'b0;
    loop_done_d = 1'b0;

    if (mode_chg_c) begin
      state_d = S_IDLE;
      addr_d  = '0;
      held_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (mode_eff_c == MODE_PLAY) begin
            state_d = S_FETCH;
          end else if (read_ready && write_ready) begin
            state_d = S_XFER;
            read_d  = 1'b1;
            write_d = 1'b1;
            wl_d    = atten_f(readdata_left, atten);
            wr_d    = atten_f(readdata_right, atten);
            if (mode_eff_c == MODE_REC) begin
              wren_d      = 1'b1;
              wdata_d     = readdata_left;
              loop_done_d = (addr_q == LAST_ADDR);
            end
          end
        end
        S_FETCH: begin
          state_d = S_WAIT;
          held_d  = 1'b0;
        end
        // RAM data is captured on the first WAIT cycle so a stalled DAC cannot lose it.
        S_WAIT: begin
          if (write_ready) begin
            state_d     = S_XFER;
            write_d     = 1'b1;
            wl_d        = atten_f(play_sample_c, atten);
            wr_d        = atten_f(play_sample_c, atten);
            loop_done_d = (addr_q == LAST_ADDR);
          end else if (!held_q) begin
            sample_d = mem_q;
            held_d   = 1'b1;
          end
        end
        S_XFER: begin
          state_d = S_GAP;
          if (mode_eff_c != MODE_PASS) begin
            addr_d = next_addr_c;
          end
        end
        S_GAP: begin
          state_d = (mode_eff_c == MODE_PLAY) ? S_FETCH : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_PASS;
      sample_q    <= '0;
      held_q      <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      wl_q        <= '0;
      wr_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
      loop_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sample_q    <= sample_d;
      held_q      <= held_d;
      read_q      <= read_d;
      write_q     <= write_d;
      wl_q        <= wl_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
      loop_done_q <= loop_done_d;
    end
  end

  assign read            = read_q;
  assign write           = write_q;
  assign writedata_left  = wl_q;
  assign writedata_right = wr_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_wren        = wren_q;
  assign loop_done       = loop_done_q;

endmodule

// File: tb/tb_audio_stream_engine.sv
// Scoreboard bench for audio_stream_engine: expected DAC and RAM writes are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_audio_stream_engine;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 16;
  localparam int unsigned LL = 4;
  localparam int unsigned LW = 2;
  localparam int unsigned TW = 3;

  logic          CLOCK_50;
  logic          reset_n;
  logic [1:0]    mode;
  logic [TW-1:0] atten;
  logic          read_ready, write_ready;
  logic [DW-1:0] readdata_left, readdata_right;
  logic          read, write;
  logic [DW-1:0] writedata_left, writedata_right;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_q;
  logic          loop_done;

  audio_stream_engine #(.DATA_W(DW), .ADDR_W(AW), .LOOP_LEN(LL), .ATTEN_W(TW)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .mode(mode), .atten(atten),
    .read_ready(read_ready), .write_ready(write_ready),
    .readdata_left(readdata_left), .readdata_right(readdata_right),
    .read(read), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q), .loop_done(loop_done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; logic ld; logic rd; } dac_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } mw_t;

  dac_t dac_q[$];
  mw_t  mw_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_seen  = 0;
  int   pk       = 0;
  int   rec_k    = 0;
  logic [DW-1:0] ref_mem [LL];

  // Synchronous sample RAM with a bench-side poke port.
  logic [DW-1:0] ram [LL];
  logic          poke_en = 1'b0;
  logic [LW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  always @(posedge CLOCK_50) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_wren) ram[mem_addr[LW-1:0]] <= mem_wdata;
    mem_q <= ram[mem_addr[LW-1:0]];
  end

  function automatic logic [DW-1:0] att(input logic [DW-1:0] x, input logic [TW-1:0] sh);
    logic signed [DW-1:0] s;
    s = $signed(x);
    return DW'(s >>> sh);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Monitor: pops expectations whenever the DUT pulses.
  logic read_prev = 1'b0, write_prev = 1'b0, wren_prev = 1'b0;
  always @(negedge CLOCK_50) begin
    dac_t e;
    mw_t  m;
    if (read_prev)  chk("read_back_to_back", 32'(read), 32'd0);
    if (write_prev) chk("write_back_to_back", 32'(write), 32'd0);
    if (wren_prev)  chk("wren_back_to_back", 32'(mem_wren), 32'd0);
    if (mem_addr >= AW'(LL)) fail_msg("mem_addr_out_of_loop");
    if (write) begin
      if (dac_q.size() == 0) fail_msg("unexpected_write");
      else begin
        e = dac_q.pop_front();
        chk("writedata_left", 32'(writedata_left), 32'(e.l));
        chk("writedata_right", 32'(writedata_right), 32'(e.r));
        chk("loop_done", 32'(loop_done), 32'(e.ld));
        chk("read_with_write", 32'(read), 32'(e.rd));
      end
      wr_seen <= wr_seen + 1;
    end else begin
      if (loop_done) fail_msg("loop_done_without_write");
      if (read) fail_msg("read_without_write");
    end
    if (mem_wren) begin
      if (mw_q.size() == 0) fail_msg("unexpected_mem_wren");
      else begin
        m = mw_q.pop_front();
        chk("mem_wr_addr", 32'(mem_addr), 32'(m.a));
        chk("mem_wr_data", 32'(mem_wdata), 32'(m.d));
      end
    end
    read_prev  <= read;
    write_prev <= write;
    wren_prev  <= mem_wren;
  end

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic wait_writes(input int tgt, input int budget, input bit rand_wr);
    int n;
    n = 0;
    while (wr_seen < tgt && n < budget) begin
      if (rand_wr) write_ready = 1'($urandom_range(1, 0));
      tick();
      n++;
    end
    if (wr_seen < tgt) begin
      fail_msg("write_timeout");
      dac_q.delete();
    end
  endtask

  task automatic poke(input int a, input logic [DW-1:0] d);
    poke_addr = LW'(a);
    poke_data = d;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  // Codec pair in passthrough or record mode; model expects one read+write per pair.
  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r,
                           input logic [TW-1:0] a, input bit rec);
    dac_t e;
    int   tgt;
    int   slot;
    slot = rec_k % int'(LL);
    e.l  = att(l, a);
    e.r  = att(r, a);
    e.ld = rec && (slot == int'(LL) - 1);
    e.rd = 1'b1;
    dac_q.push_back(e);
    if (rec) begin
      mw_q.push_back('{a: AW'(slot), d: l});
      ref_mem[slot] = l;
      rec_k++;
    end
    tgt = wr_seen + 1;
    readdata_left  = l;
    readdata_right = r;
    atten          = a;
    read_ready     = 1'b1;
    write_ready    = 1'b1;
    wait_writes(tgt, 30, 1'b0);
    read_ready  = 1'b0;
    write_ready = 1'b0;
  endtask

  // Playback of n samples continuing from loop position pk.
  task automatic play_n(input int n, input logic [TW-1:0] a, input bit rand_wr);
    dac_t e;
    int   tgt;
    int   slot;
    atten = a;
    for (int i = 0; i < n; i++) begin
      slot = pk % int'(LL);
      e.l  = att(ref_mem[slot], a);
      e.r  = e.l;
      e.ld = (slot == int'(LL) - 1);
      e.rd = 1'b0;
      dac_q.push_back(e);
      pk++;
    end
    tgt = wr_seen + n;
    write_ready = 1'b1;
    wait_writes(tgt, n * 60 + 50, rand_wr);
    write_ready = 1'b0;
  endtask

  initial begin
    dac_t e;
    int   tgt;
    reset_n = 1'b0; mode = 2'b00; atten = '0;
    read_ready = 1'b0; write_ready = 1'b0;
    readdata_left = '0; readdata_right = '0;
    for (int i = 0; i < int'(LL); i++) begin
      ref_mem[i] = DW'((i + 1) * 10);
      poke(i, ref_mem[i]);
    end
    tick();
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_wdl", 32'(writedata_left), 32'd0);
    chk("rst_wdr", 32'(writedata_right), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_loop_done", 32'(loop_done), 32'd0);
    reset_n = 1'b1;
    tick();

    // Passthrough: directed values then random pairs under the mode-11 alias.
    send_pair(24'h123456, 24'h654321, 3'd0, 1'b0);
    send_pair(24'h800000, 24'h7FFFFF, 3'd2, 1'b0);
    mode = 2'b11;
    for (int i = 0; i < 10; i++)
      send_pair(DW'($urandom), DW'($urandom), TW'($urandom_range(7, 0)), 1'b0);
    chk("pass_addr_stays_zero", 32'(mem_addr), 32'd0);

    // Playback 10,20,30,40,10 with loop_done on 40.
    mode = 2'b01;
    pk = 0;
    tick();
    play_n(5, 3'd0, 1'b0);

    // Stall in WAIT for 50 cycles; corrupt the RAM word to prove the sample is held.
    repeat (5) tick();
    chk("hold_addr_start", 32'(mem_addr), 32'd1);
    poke(1, 24'hABCDEF);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("hold_addr", 32'(mem_addr), 32'd1);
      chk("hold_no_write", 32'(write), 32'd0);
    end
    play_n(1, 3'd0, 1'b0);
    poke(1, ref_mem[1]);
    repeat (6) tick();

    // Mode 01 -> 00 while stalled in WAIT, DAC ready asserted at the same time.
    chk("pre_switch_addr", 32'(mem_addr), 32'd2);
    mode = 2'b00;
    write_ready = 1'b1;
    tick();
    chk("switch_read", 32'(read), 32'd0);
    chk("switch_write", 32'(write), 32'd0);
    chk("switch_wren", 32'(mem_wren), 32'd0);
    chk("switch_addr", 32'(mem_addr), 32'd0);
    write_ready = 1'b0;
    tick();

    // Record five pairs L=1..5: wraps to address 0 for the fifth.
    mode = 2'b10;
    rec_k = 0;
    tick();
    for (int i = 1; i <= 5; i++)
      send_pair(DW'(i), DW'($urandom), TW'($urandom_range(7, 0)), 1'b1);
    tick();
    chk("rec_mem_queue_drained", 32'(mw_q.size()), 32'd0);

    // Playback of recorded loop with random DAC backpressure.
    mode = 2'b01;
    pk = 0;
    tick();
    play_n(10, TW'($urandom_range(7, 0)), 1'b1);

    // Reset asserted while an XFER pulse is on the outputs.
    play_n(1, 3'd1, 1'b0);
    reset_n = 1'b0;
    mode = 2'b00;
    tick();
    chk("rstx_read", 32'(read), 32'd0);
    chk("rstx_write", 32'(write), 32'd0);
    chk("rstx_wren", 32'(mem_wren), 32'd0);
    chk("rstx_loop_done", 32'(loop_done), 32'd0);
    chk("rstx_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    tick();
    send_pair(24'hFFF000, 24'h000FFF, 3'd4, 1'b0);

    repeat (10) tick();
    chk("dac_queue_drained", 32'(dac_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mw_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
